mem_access_unit: RTL

- Sequential data-memory access stage sitting between the EX/MEM pipeline register and the load extension unit.
- Accepts one RV32I load or store at a time and drives a single-port data memory with a valid/ready handshake and variable wait states.
- Generates byte enables and lane-replicated store data.
- Returns load data right-aligned to byte 0 and not extended; the downstream load unit performs the sign/zero extension using the same op and func3.
- Stalls the pipeline while a transfer is outstanding.

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Sequential data-memory access stage between the EX/MEM pipeline register
// and the load extension unit. Accepts one RV32I load or store at a time,
// drives a single-port memory through a valid/ready handshake and returns
// load data right-aligned to byte 0 (no sign/zero extension here).
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   req_valid       EX/MEM holds a valid instruction
//   op, func3       opcode and size field of that instruction
//   addr, st_data   effective byte address and store data (rs2)
//   stall           hold the pipeline (combinational)
//   ld_data         right-aligned raw load data
//   ld_valid        one-cycle pulse, ld_data valid
//   misaligned      access rejected for misalignment (combinational)
//   bus_err         one-cycle pulse when the memory never answered
//   mem_*           memory request side (registered)
//   mem_ready       memory accepts/completes the request this cycle
//   mem_rdata       read data, valid with mem_ready on a read
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [6:0]  op,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [6:0]       OP_LOAD     = 7'b0000011;
    localparam logic [6:0]       OP_STORE    = 7'b0100011;
    // Timeout fires on the WAIT cycle whose miss brings the count to MAX_WAIT
    localparam logic [CNT_W-1:0] LP_LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_off;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_ld_data;
    logic             r_ld_valid;
    logic             r_bus_err;

    logic w_is_mem;
    logic w_aligned;
    logic w_idle;
    logic w_accept;
    logic w_done;
    logic w_timeout;

    // Byte enables for size func3[1:0] at byte offset off
    function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so any enabled lane carries it
    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Natural alignment check for the access size
    function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

    assign w_is_mem   = req_valid & ((op == OP_LOAD) | (op == OP_STORE));
    assign w_aligned  = f_aligned(func3[1:0], addr[1:0]);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle & w_is_mem & w_aligned;
    assign w_done     = (r_state == ST_WAIT) & mem_ready;
    assign w_timeout  = (r_state == ST_WAIT) & ~mem_ready & (r_cnt == LP_LAST_CNT);

    assign misaligned = w_idle & w_is_mem & ~w_aligned;
    // RESP does not stall: the pipeline advances as ld_valid drops
    assign stall      = w_accept | (r_state == ST_WAIT);

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign ld_data    = r_ld_data;
    assign ld_valid   = r_ld_valid;
    assign bus_err    = r_bus_err;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_WAIT;
                else          w_next_state = ST_IDLE;
            end
            ST_WAIT: begin
                if (mem_ready)      w_next_state = ST_RESP;
                else if (w_timeout) w_next_state = ST_IDLE;
                else                w_next_state = ST_WAIT;
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Wait-state counter: cleared on acceptance, counts WAIT cycles without ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_cnt <= {CNT_W{1'b0}};
        else if (w_accept)                         r_cnt <= {CNT_W{1'b0}};
        else if ((r_state == ST_WAIT) && !mem_ready) r_cnt <= r_cnt + CNT_W'(1);
        else                                       r_cnt <= r_cnt;
    end

    // Request registers: captured on acceptance, held stable through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_off       <= 2'b00;
        end else begin
            r_mem_req <= (w_next_state == ST_WAIT);
            if (w_accept) begin
                r_mem_we    <= (op == OP_STORE);
                r_mem_addr  <= {addr[31:2], 2'b00};
                r_mem_be    <= f_byte_en(func3[1:0], addr[1:0]);
                r_mem_wdata <= f_wdata(func3[1:0], st_data);
                r_off       <= addr[1:0];
            end
        end
    end

    // Response registers: aligned load data, load-valid and timeout pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_data  <= 32'h0000_0000;
            r_ld_valid <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_ld_valid <= w_done & ~r_mem_we;
            r_bus_err  <= w_timeout;
            if (w_done && !r_mem_we) r_ld_data <= mem_rdata >> {r_off, 3'b000};
        end
    end

endmodule
